controle_parametrizado: RTL and testbench
=========================================

CONTROLE_PARAMETRIZADO -- requirements
Module: controle_parametrizado

Interface
REQ-001 SHALL have parameter REG_BITS, default 3, meaning register-index width (NREGS = 2**REG_BITS, IW = 3 + 2*REG_BITS).
REQ-002 SHALL have ports: clock input 1 (rising-edge system clock); resetn input 1 (asynchronous, active-low reset).
REQ-003 SHALL have ports: iin input IW (instruction {opcode[2:0], rx, ry}); iin_valid input 1 (instruction offered); iin_ready output 1 (instruction can be accepted); hold input 1 (freeze sequencing).
REQ-004 SHALL have ports: reg_address output REG_BITS (register-file read index); regs_enable output NREGS (one-hot write enable); reg_a_enable output 1 (load A latch); alu_op_select output 2 (ALU operation).
REQ-005 SHALL have ports: alu_output_enable output 1 (load G latch); alu_output_select output 1 (1=G, 0=register bus onto write bus); imm_select output 1 (immediate onto write bus); out_enable output 1 (output-port strobe); busy output 1 (instruction in flight); done output 1 (final step of an instruction).

Function
REQ-006 SHALL use a state machine with states IDLE, T1, T2, T3; opcode/rx/ry SHALL be registered only on acceptance.
REQ-007 SHALL accept an instruction on the rising edge where iin_valid=1 and iin_ready=1; iin_ready = (state==IDLE) and not hold.
REQ-008 SHALL transition IDLE->T1 on accept, T1->T2, T2->T3, T3->IDLE, one step per clock; while hold=1 the state and latched fields SHALL stay unchanged and outputs SHALL keep their decoded values.
REQ-009 SHALL decode opcodes: 000-011 ALU ops, 100 OUT, 101 LDI, 110 NOP, 111 REP (register move).
REQ-010 SHALL drive alu_op_select = opcode[1:0] when opcode[2]=0, else 2'b11.
REQ-011 SHALL drive reg_address = rx in T1, ry in every other state.
REQ-012 SHALL assert reg_a_enable only in T1, alu_output_enable only in T2, and busy in T1, T2, T3.
REQ-013 In T3 SHALL assert: alu_output_select for opcodes 000-011; imm_select for LDI; out_enable for OUT; regs_enable one-hot bit rx for every opcode except OUT and NOP.
REQ-014 SHALL assert done for exactly one non-held cycle per instruction, in T3; regs_enable SHALL be all-zero outside T3.
REQ-015 Outputs SHALL be Moore decodes of state and latched fields only; iin changes after acceptance SHALL have no effect.
REQ-016 Minimum issue interval SHALL be 4 clocks (IDLE accept + T1..T3); an instruction presented during T1-T3 SHALL wait with iin_ready=0.

Reset
REQ-017 While resetn=0, state SHALL be IDLE and opcode, rx, ry SHALL be 0, independent of clock.
REQ-018 In reset, iin_ready SHALL equal not hold; all other outputs SHALL be 0 except reg_address (0) and alu_op_select (2'b00).
REQ-019 Reset asserted mid-instruction SHALL abort it with no regs_enable, out_enable or done pulse; after release the next accept SHALL restart at T1.

Configuration
REQ-020 Macro CONTROLE_PARAMETRIZADO_FAST_EN: when defined, accepted REP, LDI, OUT and NOP SHALL go IDLE->T3 directly (2-clock interval), with no reg_a_enable/alu_output_enable pulse; when undefined, all opcodes SHALL take IDLE->T1->T2->T3.

Verification
REQ-021 REG_BITS=3, accept iin=9'b000_010_011 -> T1: reg_address=2, reg_a_enable=1; T2: reg_address=3, alu_output_enable=1; T3: regs_enable=8'h04, alu_output_select=1, done=1.
REQ-022 Accept iin=9'b101_111_000 (LDI r7) -> T3: imm_select=1, alu_output_select=0, regs_enable=8'h80, alu_op_select=2'b11; with FAST_EN defined, T3 reached on the first clock after accept.
REQ-023 Accept iin=9'b100_001_101 (OUT) -> T3: out_enable=1, regs_enable=8'h00, reg_address=5, done=1.
REQ-024 Accept ADD, hold=1 for 3 clocks during T2 -> state stays T2, iin_ready=0; release -> T3 next clock; done pulses once.
REQ-025 Accept ADD, drop resetn in T2 -> immediately IDLE, no regs_enable/done; resetn=1 plus valid SUB (9'b001_000_001) -> accepted, alu_op_select=2'b01.
REQ-026 REG_BITS=4, accept iin=11'b111_1010_0011 (REP r10,r3) -> T3: regs_enable=16'h0400, reg_address=3, alu_output_select=0.

Source files
------------

// File: rtl/controle_parametrizado.sv
// Multi-cycle instruction sequencer: IDLE -> T1 -> T2 -> T3 with Moore-decoded datapath strobes.
// Optional macro CONTROLE_PARAMETRIZADO_FAST_EN: REP/LDI/OUT/NOP jump IDLE -> T3 directly.
module controle_parametrizado #(
  parameter int unsigned REG_BITS = 3,
  localparam int unsigned NREGS   = 2**REG_BITS,
  localparam int unsigned IW      = 3 + 2*REG_BITS
) (
  input  logic                clock,
  input  logic                resetn,
  input  logic [IW-1:0]       iin,
  input  logic                iin_valid,
  output logic                iin_ready,
  input  logic                hold,
  output logic [REG_BITS-1:0] reg_address,
  output logic [NREGS-1:0]    regs_enable,
  output logic                reg_a_enable,
  output logic [1:0]          alu_op_select,
  output logic                alu_output_enable,
  output logic                alu_output_select,
  output logic                imm_select,
  output logic                out_enable,
  output logic                busy,
  output logic                done
);

  typedef enum logic [1:0] {IDLE, T1, T2, T3} state_t;

  state_t              state, state_next;
  logic [2:0]          opcode;
  logic [REG_BITS-1:0] rx, ry;
  logic                accept;
  logic                skip_to_t3;

  assign iin_ready = (state == IDLE) && !hold;
  assign accept    = iin_valid && iin_ready;

`ifdef CONTROLE_PARAMETRIZADO_FAST_EN
  // Non-ALU opcodes need neither the A nor the G latch, so T1/T2 are skipped.
  assign skip_to_t3 = iin[IW-1];
`else
  assign skip_to_t3 = 1'b0;
`endif

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state  <= IDLE;
      opcode <= '0;
      rx     <= '0;
      ry     <= '0;
    end else begin
      state <= state_next;
      if (accept) begin
        {opcode, rx, ry} <= iin;
      end
    end
  end

  always_comb begin
    state_next = state;
    if (!hold) begin
      unique case (state)
        IDLE:    if (accept) state_next = skip_to_t3 ? T3 : T1;
        T1:      state_next = T2;
        T2:      state_next = T3;
        T3:      state_next = IDLE;
        default: state_next = IDLE;
      endcase
    end
  end

  always_comb begin
    logic is_alu, writes_reg;
    is_alu            = !opcode[2];
    writes_reg        = (opcode != 3'b100) && (opcode != 3'b110);
    reg_address       = (state == T1) ? rx : ry;
    alu_op_select     = opcode[2] ? 2'b11 : opcode[1:0];
    reg_a_enable      = (state == T1);
    alu_output_enable = (state == T2);
    busy              = (state != IDLE);
    done              = (state == T3);
    alu_output_select = 1'b0;
    imm_select        = 1'b0;
    out_enable        = 1'b0;
    regs_enable       = '0;
    if (state == T3) begin
      alu_output_select = is_alu;
      imm_select        = (opcode == 3'b101);
      out_enable        = (opcode == 3'b100);
      if (writes_reg) regs_enable[rx] = 1'b1;
    end
  end

endmodule

// File: tb/tb_controle_parametrizado.sv
// Directed bench for controle_parametrizado: vector table plus hold/reset/width sequences.
module tb_controle_parametrizado;

`ifdef CONTROLE_PARAMETRIZADO_FAST_EN
  localparam bit FAST = 1'b1;
`else
  localparam bit FAST = 1'b0;
`endif

  logic        clock = 1'b0;
  logic        resetn = 1'b0;
  logic        hold = 1'b0;
  logic [8:0]  iin = '0;
  logic        iin_valid = 1'b0;
  logic        iin_ready, reg_a_enable, alu_output_enable, alu_output_select;
  logic        imm_select, out_enable, busy, done;
  logic [2:0]  reg_address;
  logic [7:0]  regs_enable;
  logic [1:0]  alu_op_select;

  logic [10:0] iin4 = '0;
  logic        iin_valid4 = 1'b0;
  logic        iin_ready4, reg_a_enable4, alu_output_enable4, alu_output_select4;
  logic        imm_select4, out_enable4, busy4, done4;
  logic [3:0]  reg_address4;
  logic [15:0] regs_enable4;
  logic [1:0]  alu_op_select4;

  controle_parametrizado #(.REG_BITS(3)) dut (
    .clock(clock), .resetn(resetn), .iin(iin), .iin_valid(iin_valid),
    .iin_ready(iin_ready), .hold(hold), .reg_address(reg_address),
    .regs_enable(regs_enable), .reg_a_enable(reg_a_enable),
    .alu_op_select(alu_op_select), .alu_output_enable(alu_output_enable),
    .alu_output_select(alu_output_select), .imm_select(imm_select),
    .out_enable(out_enable), .busy(busy), .done(done)
  );

  controle_parametrizado #(.REG_BITS(4)) dut4 (
    .clock(clock), .resetn(resetn), .iin(iin4), .iin_valid(iin_valid4),
    .iin_ready(iin_ready4), .hold(1'b0), .reg_address(reg_address4),
    .regs_enable(regs_enable4), .reg_a_enable(reg_a_enable4),
    .alu_op_select(alu_op_select4), .alu_output_enable(alu_output_enable4),
    .alu_output_select(alu_output_select4), .imm_select(imm_select4),
    .out_enable(out_enable4), .busy(busy4), .done(done4)
  );

  always #5 clock = ~clock;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [8:0] iin;
    logic [7:0] regs;
    logic       aos;
    logic       imm;
    logic       oute;
    logic [1:0] op;
  } vec_t;

  vec_t vecs[8];

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, " busy"}, 32'(busy), 0);
    chk({tag, " done"}, 32'(done), 0);
    chk({tag, " regs_enable"}, 32'(regs_enable), 0);
    chk({tag, " out_enable"}, 32'(out_enable), 0);
    chk({tag, " reg_a_enable"}, 32'(reg_a_enable), 0);
    chk({tag, " alu_output_enable"}, 32'(alu_output_enable), 0);
  endtask

  initial begin
    vecs[0] = '{9'b000_010_011, 8'h04, 1'b1, 1'b0, 1'b0, 2'b00};
    vecs[1] = '{9'b101_111_000, 8'h80, 1'b0, 1'b1, 1'b0, 2'b11};
    vecs[2] = '{9'b100_001_101, 8'h00, 1'b0, 1'b0, 1'b1, 2'b11};
    vecs[3] = '{9'b110_011_100, 8'h00, 1'b0, 1'b0, 1'b0, 2'b11};
    vecs[4] = '{9'b111_101_110, 8'h20, 1'b0, 1'b0, 1'b0, 2'b11};
    vecs[5] = '{9'b011_000_111, 8'h01, 1'b1, 1'b0, 1'b0, 2'b11};
    vecs[6] = '{9'b010_110_001, 8'h40, 1'b1, 1'b0, 1'b0, 2'b10};
    vecs[7] = '{9'b001_100_010, 8'h10, 1'b1, 1'b0, 1'b0, 2'b01};

    // Reset state, with and without hold
    #2;
    chk_idle("reset");
    chk("reset iin_ready", 32'(iin_ready), 1);
    chk("reset reg_address", 32'(reg_address), 0);
    chk("reset alu_op_select", 32'(alu_op_select), 0);
    chk("reset imm_select", 32'(imm_select), 0);
    chk("reset alu_output_select", 32'(alu_output_select), 0);
    hold = 1'b1;
    #1;
    chk("reset hold iin_ready", 32'(iin_ready), 0);
    hold = 1'b0;
    iin = 9'h1ff;
    iin_valid = 1'b1;
    step();
    chk("reset clocked busy", 32'(busy), 0);
    chk("reset clocked alu_op_select", 32'(alu_op_select), 0);
    iin_valid = 1'b0;
    @(negedge clock);
    resetn = 1'b1;

    // Table-driven instruction sweep
    for (int i = 0; i < 8; i++) begin
      vec_t v;
      bit   fast_i;
      v = vecs[i];
      fast_i = FAST && v.iin[8];
      @(negedge clock);
      iin = v.iin;
      iin_valid = 1'b1;
      chk("vec accept iin_ready", 32'(iin_ready), 1);
      step();
      iin_valid = 1'b0;
      iin = ~v.iin;
      if (!fast_i) begin
        chk("T1 reg_address", 32'(reg_address), 32'(v.iin[5:3]));
        chk("T1 reg_a_enable", 32'(reg_a_enable), 1);
        chk("T1 busy", 32'(busy), 1);
        chk("T1 iin_ready", 32'(iin_ready), 0);
        chk("T1 regs_enable", 32'(regs_enable), 0);
        chk("T1 done", 32'(done), 0);
        step();
        chk("T2 reg_address", 32'(reg_address), 32'(v.iin[2:0]));
        chk("T2 alu_output_enable", 32'(alu_output_enable), 1);
        chk("T2 reg_a_enable", 32'(reg_a_enable), 0);
        chk("T2 iin_ready", 32'(iin_ready), 0);
        chk("T2 done", 32'(done), 0);
        step();
      end
      chk("T3 regs_enable", 32'(regs_enable), 32'(v.regs));
      chk("T3 alu_output_select", 32'(alu_output_select), 32'(v.aos));
      chk("T3 imm_select", 32'(imm_select), 32'(v.imm));
      chk("T3 out_enable", 32'(out_enable), 32'(v.oute));
      chk("T3 alu_op_select", 32'(alu_op_select), 32'(v.op));
      chk("T3 reg_address", 32'(reg_address), 32'(v.iin[2:0]));
      chk("T3 done", 32'(done), 1);
      chk("T3 reg_a_enable", 32'(reg_a_enable), 0);
      chk("T3 alu_output_enable", 32'(alu_output_enable), 0);
      chk("T3 iin_ready", 32'(iin_ready), 0);
      step();
      chk_idle("post-T3");
      chk("post-T3 iin_ready", 32'(iin_ready), 1);
    end

    // REG_BITS=4 register move
    @(negedge clock);
    iin4 = 11'b111_1010_0011;
    iin_valid4 = 1'b1;
    step();
    iin_valid4 = 1'b0;
    if (!FAST) begin
      chk("w4 T1 reg_address", 32'(reg_address4), 10);
      chk("w4 T1 reg_a_enable", 32'(reg_a_enable4), 1);
      step();
      step();
    end
    chk("w4 T3 regs_enable", 32'(regs_enable4), 32'h0400);
    chk("w4 T3 reg_address", 32'(reg_address4), 3);
    chk("w4 T3 alu_output_select", 32'(alu_output_select4), 0);
    chk("w4 T3 done", 32'(done4), 1);
    step();
    chk("w4 idle busy", 32'(busy4), 0);

    // Hold for three clocks in T2
    begin
      int done_cnt;
      done_cnt = 0;
      @(negedge clock);
      iin = 9'b000_001_010;
      iin_valid = 1'b1;
      step();
      iin_valid = 1'b0;
      step();
      @(negedge clock);
      hold = 1'b1;
      for (int k = 0; k < 3; k++) begin
        step();
        chk("hold alu_output_enable", 32'(alu_output_enable), 1);
        chk("hold iin_ready", 32'(iin_ready), 0);
        chk("hold reg_address", 32'(reg_address), 2);
        chk("hold done", 32'(done), 0);
        if (done) done_cnt++;
      end
      @(negedge clock);
      hold = 1'b0;
      step();
      chk("hold release done", 32'(done), 1);
      chk("hold release regs_enable", 32'(regs_enable), 32'h02);
      if (done) done_cnt++;
      step();
      if (done) done_cnt++;
      chk("hold done pulse count", 32'(done_cnt), 1);
      chk("hold post busy", 32'(busy), 0);
    end

    // Asynchronous reset in T2 aborts the instruction
    @(negedge clock);
    iin = 9'b000_011_001;
    iin_valid = 1'b1;
    step();
    iin_valid = 1'b0;
    step();
    chk("abort pre alu_output_enable", 32'(alu_output_enable), 1);
    resetn = 1'b0;
    #1;
    chk_idle("abort");
    chk("abort reg_address", 32'(reg_address), 0);
    step();
    chk_idle("abort clocked");
    @(negedge clock);
    resetn = 1'b1;
    iin = 9'b001_000_001;
    iin_valid = 1'b1;
    chk("restart iin_ready", 32'(iin_ready), 1);
    step();
    iin_valid = 1'b0;
    chk("restart T1 reg_a_enable", 32'(reg_a_enable), 1);
    chk("restart alu_op_select", 32'(alu_op_select), 1);
    chk("restart T1 reg_address", 32'(reg_address), 0);
    step();
    step();
    chk("restart T3 regs_enable", 32'(regs_enable), 32'h01);
    chk("restart T3 done", 32'(done), 1);
    step();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
